// File: rtl/cpu_pkg.sv
// Shared 65816 core definitions: ALU control codes, flag indices and the
// read-modify-write sequencer's operation and state encodings.
package cpu_pkg;

    // ALU flag vector bit positions
    localparam int unsigned AC = 0;
    localparam int unsigned AN = 1;
    localparam int unsigned AV = 2;
    localparam int unsigned AZ = 3;

    typedef enum logic [3:0] {
        C_ACTL_ADD = 4'd0,
        C_ACTL_SUB = 4'd1,
        C_ACTL_AND = 4'd2,
        C_ACTL_OR  = 4'd3,
        C_ACTL_XOR = 4'd4,
        C_ACTL_ASL = 4'd5,
        C_ACTL_LSR = 4'd6,
        C_ACTL_ROL = 4'd7,
        C_ACTL_ROR = 4'd8,
        C_ACTL_TSB = 4'd9,
        C_ACTL_TRB = 4'd10
    } alu_control_type;

    typedef enum logic [2:0] {
        RMW_ASL = 3'd0,
        RMW_LSR = 3'd1,
        RMW_ROL = 3'd2,
        RMW_ROR = 3'd3,
        RMW_INC = 3'd4,
        RMW_DEC = 3'd5,
        RMW_TSB = 3'd6,
        RMW_TRB = 3'd7
    } rmw_op_type;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        MODIFY = 3'd3,
        WR_HI  = 3'd4,
        WR_LO  = 3'd5
    } rmw_state_type;

    // ALU operation selected for a memory RMW instruction
    function automatic alu_control_type rmw_alu_ctl(input rmw_op_type op);
        alu_control_type ctl;
        case (op)
            RMW_ASL: ctl = C_ACTL_ASL;
            RMW_LSR: ctl = C_ACTL_LSR;
            RMW_ROL: ctl = C_ACTL_ROL;
            RMW_ROR: ctl = C_ACTL_ROR;
            RMW_INC: ctl = C_ACTL_ADD;
            RMW_DEC: ctl = C_ACTL_SUB;
            RMW_TSB: ctl = C_ACTL_TSB;
            RMW_TRB: ctl = C_ACTL_TRB;
            default: ctl = C_ACTL_ADD;
        endcase
        return ctl;
    endfunction

    // ALU b operand: 1 for INC/DEC, accumulator for bit tests, else 0
    function automatic logic [15:0] rmw_alu_b(input rmw_op_type op, input logic [15:0] acc);
        logic [15:0] b;
        case (op)
            RMW_INC, RMW_DEC: b = 16'h0001;
            RMW_TSB, RMW_TRB: b = acc;
            default:          b = 16'h0000;
        endcase
        return b;
    endfunction

    // Processor flags an RMW instruction updates; V is never touched
    function automatic logic [3:0] rmw_flag_we(input rmw_op_type op);
        logic [3:0] we;
        we = 4'b0000;
        case (op)
            RMW_ASL, RMW_LSR, RMW_ROL, RMW_ROR: begin
                we[AC] = 1'b1;
                we[AN] = 1'b1;
                we[AZ] = 1'b1;
            end
            RMW_INC, RMW_DEC: begin
                we[AN] = 1'b1;
                we[AZ] = 1'b1;
            end
            RMW_TSB, RMW_TRB: begin
                we[AZ] = 1'b1;
            end
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/rmw_sequencer.sv
// Memory read-modify-write sequencer: reads an 8/16-bit operand byte by byte,
// presents it to the ALU, latches the result and flags, and writes the result
// back high byte first. All bus and ALU-facing outputs come from registers.
module rmw_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  rmw_op_type            op,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  bit8,
    input  logic [15:0]           b_in,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic                  alu_c,
    output alu_control_type       alu_control,
    output logic                  alu_bit8,
    output logic                  alu_bcd,
    input  logic [15:0]           alu_y,
    input  logic [3:0]            alu_flgs,
    output logic [3:0]            flgs_out,
    output logic [3:0]            flgs_we
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    rmw_state_type     state_r,     state_s;
    rmw_op_type        op_r,        op_s;
    logic [ADDR_W-1:0] addr_r,      addr_s;
    logic              bit8_r,      bit8_s;
    logic              c_r,         c_s;
    logic [15:0]       operand_r,   operand_s;
    logic [15:0]       result_r,    result_s;
    logic [15:0]       alu_b_r,     alu_b_s;
    alu_control_type   alu_ctl_r,   alu_ctl_s;
    logic              busy_r,      busy_s;
    logic              done_r,      done_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
    logic              mem_rd_r,    mem_rd_s;
    logic              mem_wr_r,    mem_wr_s;
    logic [7:0]        mem_wdata_r, mem_wdata_s;
    logic [3:0]        flgs_out_r,  flgs_out_s;
    logic [3:0]        flgs_we_r,   flgs_we_s;
    logic [ADDR_W-1:0] addr_hi_s;

    assign addr_hi_s = addr_r + ADDR_ONE;

    // Next-state and next-output logic; every register holds unless a state acts on it
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        addr_s      = addr_r;
        bit8_s      = bit8_r;
        c_s         = c_r;
        operand_s   = operand_r;
        result_s    = result_r;
        alu_b_s     = alu_b_r;
        alu_ctl_s   = alu_ctl_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_rd_s    = mem_rd_r;
        mem_wr_s    = mem_wr_r;
        mem_wdata_s = mem_wdata_r;
        flgs_out_s  = flgs_out_r;
        flgs_we_s   = 4'b0000;

        case (state_r)
            IDLE: begin
                if (start) begin
                    op_s       = op;
                    addr_s     = addr;
                    bit8_s     = bit8;
                    c_s        = c_in;
                    operand_s  = 16'h0000;
                    alu_b_s    = rmw_alu_b(op, b_in);
                    alu_ctl_s  = rmw_alu_ctl(op);
                    busy_s     = 1'b1;
                    mem_rd_s   = 1'b1;
                    mem_wr_s   = 1'b0;
                    mem_addr_s = addr;
                    state_s    = RD_LO;
                end else begin
                    busy_s   = 1'b0;
                    mem_rd_s = 1'b0;
                    mem_wr_s = 1'b0;
                end
            end

            RD_LO: begin
                if (mem_ready) begin
                    operand_s[7:0] = mem_rdata;
                    if (bit8_r) begin
                        mem_rd_s = 1'b0;
                        state_s  = MODIFY;
                    end else begin
                        mem_addr_s = addr_hi_s;
                        state_s    = RD_HI;
                    end
                end else begin
                    state_s = RD_LO;
                end
            end

            RD_HI: begin
                if (mem_ready) begin
                    operand_s[15:8] = mem_rdata;
                    mem_rd_s        = 1'b0;
                    state_s         = MODIFY;
                end else begin
                    state_s = RD_HI;
                end
            end

            MODIFY: begin
                result_s   = alu_y;
                flgs_out_s = alu_flgs;
                mem_wr_s   = 1'b1;
                if (bit8_r) begin
                    mem_addr_s  = addr_r;
                    mem_wdata_s = alu_y[7:0];
                    state_s     = WR_LO;
                end else begin
                    mem_addr_s  = addr_hi_s;
                    mem_wdata_s = alu_y[15:8];
                    state_s     = WR_HI;
                end
            end

            WR_HI: begin
                if (mem_ready) begin
                    mem_addr_s  = addr_r;
                    mem_wdata_s = result_r[7:0];
                    state_s     = WR_LO;
                end else begin
                    state_s = WR_HI;
                end
            end

            WR_LO: begin
                if (mem_ready) begin
                    mem_wr_s  = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    flgs_we_s = rmw_flag_we(op_r);
                    state_s   = IDLE;
                end else begin
                    state_s = WR_LO;
                end
            end

            default: begin
                busy_s   = 1'b0;
                mem_rd_s = 1'b0;
                mem_wr_s = 1'b0;
                state_s  = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset drops any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            op_r        <= RMW_ASL;
            addr_r      <= {ADDR_W{1'b0}};
            bit8_r      <= 1'b0;
            c_r         <= 1'b0;
            operand_r   <= 16'h0000;
            result_r    <= 16'h0000;
            alu_b_r     <= 16'h0000;
            alu_ctl_r   <= C_ACTL_ADD;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
            flgs_out_r  <= 4'b0000;
            flgs_we_r   <= 4'b0000;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            addr_r      <= addr_s;
            bit8_r      <= bit8_s;
            c_r         <= c_s;
            operand_r   <= operand_s;
            result_r    <= result_s;
            alu_b_r     <= alu_b_s;
            alu_ctl_r   <= alu_ctl_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            mem_addr_r  <= mem_addr_s;
            mem_rd_r    <= mem_rd_s;
            mem_wr_r    <= mem_wr_s;
            mem_wdata_r <= mem_wdata_s;
            flgs_out_r  <= flgs_out_s;
            flgs_we_r   <= flgs_we_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_addr    = mem_addr_r;
    assign mem_rd      = mem_rd_r;
    assign mem_wr      = mem_wr_r;
    assign mem_wdata   = mem_wdata_r;
    assign alu_a       = operand_r;
    assign alu_b       = alu_b_r;
    assign alu_c       = c_r;
    assign alu_control = alu_ctl_r;
    assign alu_bit8    = bit8_r;
    assign alu_bcd     = 1'b0;
    assign flgs_out    = flgs_out_r;
    assign flgs_we     = flgs_we_r;

endmodule
